instr_dispatch: RTL

Upstream of the compute nodes: accepts a stream of `instr_t` instructions on a valid/ready input and hands each one to exactly one of `NUM_NODES` node_top instances. Selection is round-robin, skipping any node that asserts `busy`. A one-entry holding register decouples the producer from node backpressure. Saturating stall and dispatch counters support performance debug.

---
 rtl/instr_dispatch_pkg.sv | 16 +
 rtl/instr_dispatch_rr_select.sv | 32 +++
 rtl/instr_dispatch.sv | 109 ++++++++++
 3 files changed

// File: rtl/instr_dispatch_pkg.sv
// Shared types for the instruction dispatcher: instruction word layout and
// node index type sized for the default node count.
package instr_dispatch_pkg;

  localparam int DEFAULT_NUM_NODES = 4;
  localparam int NODE_IDX_W        = $clog2(DEFAULT_NUM_NODES);

  typedef logic [NODE_IDX_W-1:0] node_idx_t;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [7:0]  tag;
    logic [15:0] operand;
  } instr_t;

endpackage

// File: rtl/instr_dispatch_rr_select.sv
// Combinational round-robin picker: first non-busy node at or after the
// pointer, wrapping. Reusable for any request/busy arbitration.
module rr_select #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [IDX_W-1:0] i_rr_ptr,
  input  logic [N-1:0]     i_node_busy,
  output logic [IDX_W-1:0] o_sel,
  output logic             o_any_free
);

  logic             w_found;
  logic [IDX_W-1:0] w_idx;

  // N is a power of two, so IDX_W-bit addition wraps modulo N for free.
  always_comb begin
    o_sel   = i_rr_ptr;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = IDX_W'(i_rr_ptr + IDX_W'(k));
      if (!w_found && !i_node_busy[w_idx]) begin
        o_sel   = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign o_any_free = ~&i_node_busy;

endmodule

// File: rtl/instr_dispatch.sv
// Instruction dispatcher: one-entry holding register feeding NUM_NODES nodes
// round-robin, skipping busy nodes, with saturating dispatch/stall counters.
module instr_dispatch
  import instr_dispatch_pkg::*;
#(
  parameter int NUM_NODES = DEFAULT_NUM_NODES,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  instr_t               in_instr,
  input  logic                 in_valid,
  output logic                 in_ready,
  output instr_t               node_instr,
  output logic [NUM_NODES-1:0] node_valid,
  input  logic [NUM_NODES-1:0] node_busy,
  output logic                 all_busy,
  output logic [CNT_W-1:0]     dispatch_cnt,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [1:0]           dbg_state
);

  localparam int IDX_W = $clog2(NUM_NODES);

  // Handshake: a transfer happens on a rising edge where in_valid and
  // in_ready are both high; node_valid[i] is a one-cycle write strobe that
  // is only raised on a node whose busy is low in that same cycle.
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADED  = 2'd1,
    ST_STALLED = 2'd2
  } disp_state_t;

  disp_state_t      r_state;
  instr_t           r_hold;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [CNT_W-1:0] r_dispatch_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [IDX_W-1:0] w_sel;
  logic             w_any_free;
  logic             w_fire;
  logic             w_accept;

  rr_select #(
    .N     (NUM_NODES),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .i_rr_ptr    (r_rr_ptr),
    .i_node_busy (node_busy),
    .o_sel       (w_sel),
    .o_any_free  (w_any_free)
  );

  // Reset suppresses dispatch so a discarded instruction never reaches a node.
  assign w_fire   = (r_state != ST_EMPTY) & w_any_free & ~reset;
  assign in_ready = (r_state == ST_EMPTY) | w_fire;
  assign w_accept = in_valid & in_ready;
  assign all_busy = (r_state != ST_EMPTY) & (&node_busy);

  always_comb begin
    node_valid = '0;
    if (w_fire) node_valid[w_sel] = 1'b1;
  end

  assign node_instr   = r_hold;
  assign dispatch_cnt = r_dispatch_cnt;
  assign stall_cnt    = r_stall_cnt;
  assign dbg_state    = r_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_EMPTY;
      r_hold         <= '0;
      r_rr_ptr       <= '0;
      r_dispatch_cnt <= '0;
      r_stall_cnt    <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_hold  <= in_instr;
            r_state <= ST_LOADED;
          end
        end
        ST_LOADED, ST_STALLED: begin
          if (w_fire && w_accept) begin
            r_hold  <= in_instr;
            r_state <= ST_LOADED;
          end else if (w_fire) begin
            r_state <= ST_EMPTY;
          end else begin
            r_state <= ST_STALLED;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase

      if (w_fire) r_rr_ptr <= w_sel + 1'b1;

      if (w_fire && !(&r_dispatch_cnt))
        r_dispatch_cnt <= r_dispatch_cnt + 1'b1;

      if ((r_state == ST_STALLED) && !(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule
